ifetch_stage: RTL and testbench

IFETCH_STAGE -- requirements
Module: ifetch_stage

---
 rtl/ifetch_stage_pkg.sv | 12 +
 rtl/ifetch_stage_if.sv | 27 ++
 rtl/ifetch_stage_fetch_buf.sv | 51 +++++
 rtl/ifetch_stage.sv | 73 +++++++
 tb/tb_ifetch_stage.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/ifetch_stage_pkg.sv
// Shared defaults and occupancy encodings for the instruction fetch stage.
// Optional entry parity is enabled with the IFETCH_PARITY_EN macro.
package ifetch_stage_pkg;
  localparam int PC_W_DEF   = 8;
  localparam int INST_W_DEF = 20;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;
endpackage

// File: rtl/ifetch_stage_if.sv
// Instruction memory and decode-side bus of the fetch stage.
// IFETCH_PARITY_EN adds imem_par / parity_err.
interface ifetch_stage_if import ifetch_stage_pkg::*; #(
  parameter int PC_W   = PC_W_DEF,
  parameter int INST_W = INST_W_DEF
);
  logic [PC_W-1:0]   imem_addr;
  logic [INST_W-1:0] imem_data;
  logic              stall;
  logic [INST_W-1:0] ir_out;
  logic [PC_W-1:0]   ir_pc;
  logic              ir_valid;
`ifdef IFETCH_PARITY_EN
  logic              imem_par;
  logic              parity_err;

  modport master (output imem_addr, ir_out, ir_pc, ir_valid, parity_err,
                  input  imem_data, imem_par, stall);
  modport slave  (input  imem_addr, ir_out, ir_pc, ir_valid, parity_err,
                  output imem_data, imem_par, stall);
`else
  modport master (output imem_addr, ir_out, ir_pc, ir_valid,
                  input  imem_data, stall);
  modport slave  (input  imem_addr, ir_out, ir_pc, ir_valid,
                  output imem_data, stall);
`endif
endinterface

// File: rtl/ifetch_stage_fetch_buf.sv
// Two-entry in-order buffer between the ROM read and the decoder.
// flush drops all entries; push alongside pop is accepted even when full.
module fetch_buf import ifetch_stage_pkg::*; #(
  parameter int W = 28
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  occ_e         state, state_nx;
  logic [W-1:0] mem [2];
  logic         wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  assign empty   = (state == OCC_EMPTY);
  assign full    = (state == OCC_FULL);
  assign do_pop  = pop & ~empty & ~flush & ~reset;
  assign do_push = push & (~full | do_pop) & ~flush & ~reset;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state  <= OCC_EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      state <= state_nx;
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_comb begin
    state_nx = state;
    unique case ({do_push, do_pop})
      2'b10:   state_nx = (state == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
      2'b01:   state_nx = (state == OCC_FULL)  ? OCC_ONE : OCC_EMPTY;
      default: state_nx = state;
    endcase
  end
endmodule

// File: rtl/ifetch_stage.sv
// Fetch stage: issues ROM reads, buffers returned words, presents them to decode.
// Define IFETCH_PARITY_EN to carry and check a per-entry parity bit.
module ifetch_stage import ifetch_stage_pkg::*; #(
  parameter int PC_W   = PC_W_DEF,
  parameter int INST_W = INST_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] pc_in,
  input  logic            branch,
  output logic            pc_advance,
  ifetch_stage_if.master  bus
);
`ifdef IFETCH_PARITY_EN
  localparam int EW = INST_W + PC_W + 1;
`else
  localparam int EW = INST_W + PC_W;
`endif

  logic              req_vld;
  logic [PC_W-1:0]   req_pc;
  logic              valid, pop, full, empty;
  logic [EW-1:0]     din, dout;
  logic [INST_W-1:0] head_inst;
  logic [PC_W-1:0]   head_pc;
  logic [1:0]        occ_cnt;
  logic [2:0]        proj;

  assign bus.imem_addr = pc_in;

  assign valid        = ~reset & ~empty;
  assign pop          = valid & ~bus.stall;
  assign bus.ir_valid = valid;
  assign bus.ir_out   = valid ? head_inst : '0;
  assign bus.ir_pc    = valid ? head_pc   : '0;

  // Issue only if the word it returns is guaranteed a free slot next cycle.
  assign occ_cnt    = full ? 2'd2 : (empty ? 2'd0 : 2'd1);
  assign proj       = 3'(occ_cnt) + 3'(req_vld) - 3'(pop);
  assign pc_advance = ~reset & ~branch & (proj <= 3'd1);

  always_ff @(posedge clk) begin
    if (reset || branch) begin
      req_vld <= 1'b0;
      req_pc  <= '0;
    end else begin
      req_vld <= pc_advance;
      if (pc_advance) req_pc <= pc_in;
    end
  end

`ifdef IFETCH_PARITY_EN
  logic head_par;
  assign din = {bus.imem_par, bus.imem_data, req_pc};
  assign {head_par, head_inst, head_pc} = dout;
  assign bus.parity_err = valid & ((^bus.ir_out) != head_par);
`else
  assign din = {bus.imem_data, req_pc};
  assign {head_inst, head_pc} = dout;
`endif

  fetch_buf #(.W(EW)) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (req_vld),
    .pop   (pop),
    .flush (branch),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );
endmodule

// File: tb/tb_ifetch_stage.sv
// Randomized bench for ifetch_stage against a queue-level fetch model.
// Parity checks are active when IFETCH_PARITY_EN is defined.
module tb_ifetch_stage;
  import ifetch_stage_pkg::*;

  logic       clk = 1'b0;
  logic       reset, branch;
  logic [7:0] pc, tgt;
  logic       pc_advance;
  int         n_cmp = 0, n_err = 0;

  logic [19:0] rom     [256];
  logic        rom_par [256];

  // model state: words returned and buffered, plus the read in flight
  logic [7:0] q[$];
  logic       inf_v = 1'b0;
  logic [7:0] inf_pc;

  ifetch_stage_if #(.PC_W(8), .INST_W(20)) bus ();

  ifetch_stage #(.PC_W(8), .INST_W(20)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_in      (pc),
    .branch     (branch),
    .pc_advance (pc_advance),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  // program counter and synchronous ROM environment
  always @(posedge clk) begin
    if (reset)           pc <= 8'h00;
    else if (branch)     pc <= tgt;
    else if (pc_advance) pc <= pc + 8'h01;
    bus.imem_data <= rom[bus.imem_addr];
`ifdef IFETCH_PARITY_EN
    bus.imem_par  <= rom_par[bus.imem_addr];
`endif
  end

  function automatic logic exp_adv();
    int s, p;
    s = q.size();
    p = (s != 0 && !bus.stall) ? 1 : 0;
    return !reset && !branch && (s + int'(inf_v) - p) <= 1;
  endfunction

  always @(posedge clk) begin
    logic adv, popm;
    adv  = exp_adv();
    popm = (q.size() != 0) && !bus.stall;
    if (reset || branch) begin
      q.delete();
      inf_v = 1'b0;
    end else begin
      if (popm) void'(q.pop_front());
      if (inf_v) q.push_back(inf_pc);
      inf_v  = adv;
      inf_pc = pc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // drive one cycle of inputs, then compare outputs against the model
  task automatic cyc(input logic r, input logic br, input logic st, input logic [7:0] t);
    logic ev;
    @(negedge clk);
    reset = r; branch = br; bus.stall = st; tgt = t;
    #1;
    ev = !reset && q.size() != 0;
    chk("valid", bus.ir_valid, ev);
    chk("adv", pc_advance, exp_adv());
    if (ev) begin
      chk("pc", bus.ir_pc, q[0]);
      chk("inst", bus.ir_out, rom[q[0]]);
    end else if (reset) begin
      chk("rst_out", bus.ir_out, 0);
      chk("rst_pc", bus.ir_pc, 0);
    end
`ifdef IFETCH_PARITY_EN
    chk("perr", bus.parity_err, ev && (rom_par[q[0]] != ^rom[q[0]]));
`endif
  endtask

  task automatic release_seq();
    cyc(0, 0, 0, 0);
    chk("rel_adv", pc_advance, 1);
    chk("rel_v0", bus.ir_valid, 0);
    cyc(0, 0, 0, 0);
    chk("rel_v1", bus.ir_valid, 0);
    cyc(0, 0, 0, 0);
    chk("rel_valid", bus.ir_valid, 1);
    chk("rel_inst", bus.ir_out, 20'hA5A5);
    chk("rel_pc", bus.ir_pc, 8'h00);
  endtask

  initial begin
    logic [7:0]  last;
    logic [19:0] held;
    logic [7:0]  held_pc;
    logic        r, br, st;

    for (int i = 0; i < 256; i++) begin
      rom[i]     = 20'($urandom);
      rom_par[i] = ^rom[i];
    end
    rom[0]     = 20'hA5A5;
    rom_par[0] = ^rom[0];
`ifdef IFETCH_PARITY_EN
    rom_par[3] = ~(^rom[3]);
`endif
    reset = 1'b1; branch = 1'b0; bus.stall = 1'b0; tgt = 8'h00;

    repeat (3) cyc(1, 0, 0, 0);
    chk("rst_v", bus.ir_valid, 0);
    chk("rst_adv", pc_advance, 0);
    release_seq();

    // streaming
    last = bus.ir_pc;
    repeat (10) begin
      cyc(0, 0, 0, 0);
      chk("stream_inc", bus.ir_pc, 8'(last + 8'h01));
      last = bus.ir_pc;
    end

    // stall 5 cycles: buffer fills, head holds
    cyc(0, 0, 1, 0);
    held = bus.ir_out; held_pc = bus.ir_pc;
    repeat (4) cyc(0, 0, 1, 0);
    chk("stall_adv", pc_advance, 0);
    chk("stall_hold", bus.ir_out, held);
    chk("stall_hold_pc", bus.ir_pc, held_pc);
    cyc(0, 0, 0, 0);
    last = bus.ir_pc;
    repeat (6) begin
      cyc(0, 0, 0, 0);
      chk("resume_inc", bus.ir_pc, 8'(last + 8'h01));
      last = bus.ir_pc;
    end

    // branch to 40h while full and stalled
    repeat (3) cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 8'h40);
    cyc(0, 0, 0, 0);
    chk("br_flush_v", bus.ir_valid, 0);
    cyc(0, 0, 0, 0);
    chk("br_wait_v", bus.ir_valid, 0);
    cyc(0, 0, 0, 0);
    chk("br_valid", bus.ir_valid, 1);
    chk("br_pc", bus.ir_pc, 8'h40);

    // random traffic
    repeat (600) begin
      r  = ($urandom_range(0, 99) < 2);
      br = !r && ($urandom_range(0, 99) < 6);
      st = ($urandom_range(0, 99) < 35);
      cyc(r, br, st, 8'($urandom));
    end

    // reset mid-stream with a full buffer
    repeat (3) cyc(0, 0, 0, 0);
    repeat (3) cyc(0, 0, 1, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 0, 0);
    chk("mrst_v", bus.ir_valid, 0);
    chk("mrst_out", bus.ir_out, 0);
    chk("mrst_pc", bus.ir_pc, 0);
    chk("mrst_adv", pc_advance, 0);
    release_seq();
    for (int i = 1; i <= 6; i++) begin
      cyc(0, 0, 0, 0);
      chk("post_pc", bus.ir_pc, 8'(i));
`ifdef IFETCH_PARITY_EN
      chk("par_flag", bus.parity_err, (i == 3));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
